// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Serializes a WIDTH-bit word onto serial_out, one bit per clock. A word is
// taken through a load/ready handshake. frame marks valid bits, and done
// pulses on the last bit. Frames can follow back to back with no idle gap.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// after the data bits, so each frame is WIDTH+1 bits long.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             serial_out,
    output logic             frame,
    output logic             done
);

`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] sr_shift_d;
    logic             data_bit;
    logic             last_bit;
    logic             accept;
    logic             tx_bit;

    // Pick the shift direction and the output tap so the next bit to send
    // always sits at the output end of the shift register.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign sr_shift_d = {sr_q[WIDTH-2:0], 1'b0};
            assign data_bit   = sr_q[WIDTH-1];
        end else begin : g_lsb_first
            assign sr_shift_d = {1'b0, sr_q[WIDTH-1:1]};
            assign data_bit   = sr_q[0];
        end
    endgenerate

    // A new word can enter when idle or during the last bit, which lets
    // frames follow each other with no gap.
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign ready    = (state_q == IDLE) || last_bit;
    assign accept   = load && ready;

`ifdef PISO_TX_PARITY_EN
    logic par_q;

    // Capture even parity of the accepted word so it can follow the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^data_in;
        end
    end

    // The final bit of a frame carries parity. Every other bit is data.
    assign tx_bit = (cnt_q == LAST_CNT) ? par_q : data_bit;
`else
    assign tx_bit = data_bit;
`endif

    // Frame sequencer: load the word, shift it out, and chain or stop at the last bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        sr_q    <= data_in;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt_q != LAST_CNT) begin
                        sr_q  <= sr_shift_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (accept) begin
                        sr_q  <= data_in;
                        cnt_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so load and data_in
    // have no combinational path to them.
    assign frame      = (state_q == SHIFT);
    assign done       = last_bit;
    assign serial_out = frame ? tx_bit : 1'b0;

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx. Two instances, MSB-first and LSB-first, share the same
// inputs. Their outputs are checked every cycle against a frame-level
// reference model that holds each frame as a list of expected bits.
module tb_piso_tx;

    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    logic         load;
    logic         ready_m, ser_m, frame_m, done_m;
    logic         ready_l, ser_l, frame_l, done_l;

    int tests_run;
    int tests_failed;

    // Reference model: pos = index of the bit on the line, -1 when idle.
    int   pos;
    logic exp_m[FL];
    logic exp_l[FL];

    piso_tx #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .ready(ready_m), .serial_out(ser_m), .frame(frame_m), .done(done_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .ready(ready_l), .serial_out(ser_l), .frame(frame_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] obs_vec;
    assign obs_vec = {ready_m, frame_m, done_m, ser_m, ready_l, frame_l, done_l, ser_l};

    // Expected {ready,frame,done,serial} for both instances from the model.
    function automatic logic [7:0] exp_vec();
        logic rdy, fr, dn, sm, sl;
        if (pos < 0) begin
            rdy = 1'b1; fr = 1'b0; dn = 1'b0; sm = 1'b0; sl = 1'b0;
        end else begin
            rdy = (pos == FL - 1);
            fr  = 1'b1;
            dn  = (pos == FL - 1);
            sm  = exp_m[pos];
            sl  = exp_l[pos];
        end
        return {rdy, fr, dn, sm, rdy, fr, dn, sl};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, then settle.
    task automatic cyc(input logic ld, input logic [W-1:0] d);
        logic acc;
        load    = ld;
        data_in = d;
        @(posedge clk);
        if (!rst) begin
            pos = -1;
        end else begin
            acc = ld && (pos < 0 || pos == FL - 1);
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    exp_m[i] = d[W-1-i];
                    exp_l[i] = d[i];
                end
                if (FL > W) begin
                    exp_m[FL-1] = ^d;
                    exp_l[FL-1] = ^d;
                end
                pos = 0;
            end else if (pos >= 0) begin
                pos = pos + 1;
                if (pos == FL) pos = -1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pos = -1;
        for (int c = 0; c < 6; c++) begin
            cyc(c[0], W'($urandom));
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec());
            end
        end
        rst = 1'b1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_single(input logic [W-1:0] word);
        cyc(1'b1, word);
        for (int c = 0; c < FL + 3; c++) begin
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL single word=%h cyc=%0d got=%b exp=%b", word, c, obs_vec, exp_vec());
            end
            cyc(1'b0, W'($urandom));
        end
        $display("[TB] test_single word=%h done", word);
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        cyc(1'b1, 8'hFF);
        for (int c = 0; c < 2 * FL + 2; c++) begin
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec());
            end
            if (done_m) dones++;
            cyc(c == FL - 1, 8'h00);
        end
        tests_run++;
        if (dones !== 2) begin
            tests_failed++;
            $display("FAIL back_to_back_dones got=%0d exp=2", dones);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_load_busy();
        cyc(1'b1, 8'hF0);
        for (int c = 0; c < FL + 2; c++) begin
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL load_busy cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec());
            end
            cyc(c == 3, 8'h0F);
        end
        $display("[TB] test_load_busy done");
    endtask

    task automatic test_continuous_load();
        for (int c = 0; c < 3 * FL + 1; c++) begin
            cyc(1'b1, W'($urandom));
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL continuous cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec());
            end
        end
        for (int c = 0; c < FL; c++) cyc(1'b0, 8'h00);
        $display("[TB] test_continuous_load done");
    endtask

    task automatic test_reset_mid_frame();
        cyc(1'b1, 8'hAA);
        for (int c = 0; c < 4; c++) cyc(1'b0, 8'h00);
        // Bit 4 is on the line now; drop reset between clock edges.
        rst = 1'b0;
        pos = -1;
        #1;
        tests_run++;
        if (obs_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_mid_frame_async got=%b exp=%b", obs_vec, exp_vec());
        end
        cyc(1'b0, 8'h00);
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        tests_run++;
        if (obs_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_mid_frame_idle got=%b exp=%b", obs_vec, exp_vec());
        end
        $display("[TB] test_reset_mid_frame done");
        test_single(8'h81);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            cyc(($urandom_range(0, 9) < 3), W'($urandom));
            tests_run++;
            if (obs_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec());
            end
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        pos          = -1;
        load         = 1'b0;
        data_in      = '0;
        rst          = 1'b0;
        #2;
        test_reset();
        test_single(8'hA5);
        test_single(8'h01);
        test_single(8'h07);
        test_back_to_back();
        test_load_busy();
        test_continuous_load();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before completion");
        $fatal(1, "timeout");
    end

endmodule
